oai21_filt_bank: RTL and testbench

Parametrised, clocked bank of WIDTH OAI21 channels (QN = ~((IN1 | IN2) & IN3)) with a per-channel glitch filter and a supply-sense power sequencer. Outputs are forced low until the VDD/VSS sense pins have reported a good rail for a programmable settle time. The block replaces single combinational OAI21 cells wherever a debounced, power-qualified, registered result is needed.

---
 rtl/oai21_filt_bank.sv | 128 ++++++++++++
 tb/tb_oai21_filt_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oai21_filt_bank.sv
// Bank of WIDTH registered OAI21 channels. Each channel has a persistence filter, and the
// whole bank is gated by a supply-sense sequencer (OFF -> SETTLE -> ACTIVE).
module oai21_filt_bank #(
   parameter int WIDTH         = 8,
   parameter int FILT_CYCLES   = 3,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [WIDTH-1:0] IN3,
   input  logic             VDD,
   input  logic             VSS,
   input  logic             en,
   output logic [WIDTH-1:0] QN,
   output logic [WIDTH-1:0] chg,
   output logic             pwr_ok,
   output logic [1:0]       dbg_state_o
);

   localparam int FW = $clog2(FILT_CYCLES) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [FW-1:0] F_MAX = FW'(FILT_CYCLES - 1);
   localparam logic [SW-1:0] S_MAX = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [SW-1:0]    scnt_q, scnt_d;
   logic [WIDTH-1:0] qn_q, qn_d;
   logic [WIDTH-1:0] chg_q, chg_d;
   logic [FW-1:0]    fcnt_q [WIDTH];
   logic [FW-1:0]    fcnt_d [WIDTH];

   logic             rail_good;
   logic [WIDTH-1:0] raw;

   assign rail_good = VDD & ~VSS;
   assign raw       = ~((IN1 | IN2) & IN3);

   // Sequencer: any bad-rail edge drops straight to OFF, no filtering.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         ST_OFF: begin
            if (rail_good) begin
               state_d = ST_SETTLE;
               scnt_d  = '0;
            end
         end
         ST_SETTLE: begin
            if (!rail_good) begin
               state_d = ST_OFF;
               scnt_d  = '0;
            end else if (scnt_q == S_MAX) begin
               state_d = ST_ACTIVE;
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end
         ST_ACTIVE: begin
            if (!rail_good) begin
               state_d = ST_OFF;
               scnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_OFF;
            scnt_d  = '0;
         end
      endcase
   end

   // Channel filters only run when the edge itself sees ACTIVE with a good rail.
   always_comb begin
      qn_d  = qn_q;
      chg_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         fcnt_d[i] = '0;
      end
      if ((state_q != ST_ACTIVE) || !rail_good) begin
         qn_d = '0;
      end else if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (raw[i] != qn_q[i]) begin
               if (fcnt_q[i] == F_MAX) begin
                  qn_d[i]  = raw[i];
                  chg_d[i] = 1'b1;
               end else begin
                  fcnt_d[i] = fcnt_q[i] + FW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_OFF;
         scnt_q  <= '0;
         qn_q    <= '0;
         chg_q   <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            fcnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         qn_q    <= qn_d;
         chg_q   <= chg_d;
         for (int i = 0; i < WIDTH; i++) begin
            fcnt_q[i] <= fcnt_d[i];
         end
      end
   end

   assign QN          = qn_q;
   assign chg         = chg_q;
   assign pwr_ok      = (state_q == ST_ACTIVE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_oai21_filt_bank.sv
// Bench for oai21_filt_bank: directed scenarios plus random traffic against a rail-run /
// disagreement-run model, and an exhaustive sweep of a FILT_CYCLES=1 instance.
module tb_oai21_filt_bank;

   localparam int W = 4;
   localparam int F = 3;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [W-1:0] in1 = '0, in2 = '0, in3 = '0;
   logic         vdd = 1'b0, vss = 1'b1, en = 1'b0;
   logic [W-1:0] qn, chg;
   logic         pwr_ok;
   logic [1:0]   dbg;

   logic [W-1:0] b_in1 = '1, b_in2 = '0, b_in3 = '1;
   logic         b_vdd = 1'b1, b_vss = 1'b0, b_en = 1'b1;
   logic [W-1:0] b_qn, b_chg;
   logic         b_pwr_ok;
   logic [1:0]   b_dbg;

   int total = 0;
   int bad   = 0;

   // Clock / reset
   always #5 clk = ~clk;

   oai21_filt_bank #(.WIDTH(W), .FILT_CYCLES(F), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .IN1(in1), .IN2(in2), .IN3(in3),
      .VDD(vdd), .VSS(vss), .en(en),
      .QN(qn), .chg(chg), .pwr_ok(pwr_ok), .dbg_state_o(dbg)
   );

   oai21_filt_bank #(.WIDTH(W), .FILT_CYCLES(1), .SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .IN1(b_in1), .IN2(b_in2), .IN3(b_in3),
      .VDD(b_vdd), .VSS(b_vss), .en(b_en),
      .QN(b_qn), .chg(b_chg), .pwr_ok(b_pwr_ok), .dbg_state_o(b_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outputs enabled once the rail has been good for more than S consecutive edges;
   // a channel flips after F consecutive enabled edges where the gate disagrees with it.
   int           m_run = 0;
   logic [W-1:0] m_qn  = '0;
   logic [W-1:0] m_chg = '0;
   int           m_dis [W];
   logic [W-1:0] m_raw;
   bit           m_act, m_rg;

   initial begin
      for (int i = 0; i < W; i++) m_dis[i] = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_run = 0;
            m_qn  = '0;
            m_chg = '0;
            for (int i = 0; i < W; i++) m_dis[i] = 0;
         end else begin
            m_act = (m_run > S);
            m_rg  = vdd && !vss;
            m_raw = ~((in1 | in2) & in3);
            m_chg = '0;
            if (!(m_act && m_rg)) begin
               m_qn = '0;
               for (int i = 0; i < W; i++) m_dis[i] = 0;
            end else if (!en) begin
               for (int i = 0; i < W; i++) m_dis[i] = 0;
            end else begin
               for (int i = 0; i < W; i++) begin
                  if (m_raw[i] != m_qn[i]) begin
                     m_dis[i]++;
                     if (m_dis[i] == F) begin
                        m_qn[i]  = m_raw[i];
                        m_chg[i] = 1'b1;
                        m_dis[i] = 0;
                     end
                  end else begin
                     m_dis[i] = 0;
                  end
               end
            end
            if (m_rg) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else      m_run = 0;
         end
      end
   end

   // Scoreboard compare, every cycle on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         check("m_qn",     32'(qn),     32'(m_qn));
         check("m_chg",    32'(chg),    32'(m_chg));
         check("m_pwr_ok", 32'(pwr_ok), 32'(m_run > S));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic power_up_check(input string tag);
      vdd = 1'b1; vss = 1'b0; en = 1'b1;
      in1 = '0; in2 = '0; in3 = '0;
      for (int e = 0; e <= 8; e++) begin
         @(negedge clk);
         if (e == 3) check({tag, "_pwr_e3"}, 32'(pwr_ok), 32'd0);
         if (e == 4) check({tag, "_pwr_e4"}, 32'(pwr_ok), 32'd1);
         if (e == 6) check({tag, "_qn_e6"},  32'(qn),     32'h0);
         if (e == 7) begin
            check({tag, "_qn_e7"},  32'(qn),  32'hF);
            check({tag, "_chg_e7"}, 32'(chg), 32'hF);
         end
         if (e == 8) check({tag, "_chg_e8"}, 32'(chg), 32'h0);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] exp_b, prev_b;
      logic [2:0]   c;
      int           waited;

      tick(3);
      check("rst_qn",  32'(qn),     32'h0);
      check("rst_chg", 32'(chg),    32'h0);
      check("rst_pwr", 32'(pwr_ok), 32'h0);
      rst = 1'b0;

      power_up_check("pu");

      // Filtering: raw becomes 4'b1110
      in1 = 4'b0001; in3 = 4'b0011;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         if (e < 3)  check("filt_hold", 32'(qn), 32'hF);
         if (e == 3) begin
            check("filt_qn",  32'(qn),  32'hE);
            check("filt_chg", 32'(chg), 32'h1);
         end
         if (e == 4) check("filt_chg_off", 32'(chg), 32'h0);
      end

      // Two-edge glitch on channel 1 must be swallowed
      in1 = 4'b0011; in3 = 4'b0001;
      tick(1);
      in3 = 4'b0011;
      tick(2);
      in3 = 4'b0001;
      for (int e = 0; e < 3; e++) begin
         @(negedge clk);
         check("glitch_qn",  32'(qn),  32'hE);
         check("glitch_chg", 32'(chg), 32'h0);
      end

      // Rail loss
      in1 = '0; in2 = '0; in3 = '0;
      tick(4);
      check("rl_pre_qn", 32'(qn), 32'hF);
      vss = 1'b1;
      @(negedge clk);
      check("rl_qn",  32'(qn),     32'h0);
      check("rl_pwr", 32'(pwr_ok), 32'h0);
      check("rl_chg", 32'(chg),    32'h0);
      vss = 1'b0;
      for (int e = 0; e <= 4; e++) begin
         @(negedge clk);
         if (e == 3) check("rl_pwr_e3", 32'(pwr_ok), 32'd0);
         if (e == 4) check("rl_pwr_e4", 32'(pwr_ok), 32'd1);
      end
      tick(3);
      check("rl_qn_back", 32'(qn), 32'hF);

      // Enable hold
      en = 1'b0; in1 = '1; in3 = '1;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         check("en_hold_qn", 32'(qn), 32'hF);
      end
      en = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk);
         if (e < 3) check("en_wait_qn", 32'(qn), 32'hF);
         else begin
            check("en_qn",  32'(qn),  32'h0);
            check("en_chg", 32'(chg), 32'hF);
         end
      end

      // Reset during SETTLE
      vss = 1'b1;
      tick(1);
      vss = 1'b0;
      tick(2);
      #2 rst = 1'b1;
      #1;
      check("rst_settle_pwr", 32'(pwr_ok), 32'h0);
      check("rst_settle_qn",  32'(qn),     32'h0);
      tick(2);
      rst = 1'b0;
      power_up_check("rs1");

      // Reset mid-filter in ACTIVE: outputs drop without a clock edge
      in1 = '1; in3 = '1;
      tick(2);
      check("rst_act_pre_qn", 32'(qn), 32'hF);
      #2 rst = 1'b1;
      #1;
      check("rst_act_qn",  32'(qn),     32'h0);
      check("rst_act_pwr", 32'(pwr_ok), 32'h0);
      check("rst_act_chg", 32'(chg),    32'h0);
      tick(1);
      rst = 1'b0;
      power_up_check("rs2");

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in1 = W'($urandom_range(0, 15));
            in2 = W'($urandom_range(0, 15));
            in3 = W'($urandom_range(0, 15));
         end
         en  = ($urandom_range(0, 9) != 0);
         vss = ($urandom_range(0, 39) == 0);
         vdd = ($urandom_range(0, 49) != 0);
         @(negedge clk);
      end

      // FILT_CYCLES=1 / SETTLE_CYCLES=1 instance: exhaustive per-channel sweep
      waited = 0;
      while (!b_pwr_ok && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("b_pwr_up",  32'(b_pwr_ok), 32'd1);
      check("b_qn_idle", 32'(b_qn),     32'h0);
      prev_b = '0;
      for (int s = 0; s < 24; s++) begin
         for (int i = 0; i < W; i++) begin
            c = (s < 8) ? 3'((s + i) % 8) : 3'($urandom_range(0, 7));
            b_in1[i] = c[0];
            b_in2[i] = c[1];
            b_in3[i] = c[2];
         end
         exp_b = ~((b_in1 | b_in2) & b_in3);
         @(negedge clk);
         check("b_qn",  32'(b_qn),  32'(exp_b));
         check("b_chg", 32'(b_chg), 32'(exp_b ^ prev_b));
         prev_b = exp_b;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
